// File: rtl/color_cfg_pkg.sv
// Shared definitions for the color modifier configuration scheduler:
// field addresses and the commit FSM state type.
package color_cfg_pkg;

  localparam logic [1:0] FIELD_GAIN       = 2'd0;
  localparam logic [1:0] FIELD_HUE        = 2'd1;
  localparam logic [1:0] FIELD_BRIGHTNESS = 2'd2;
  localparam logic [1:0] FIELD_SATURATION = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    APPLY = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/color_cfg_rr_arb.sv
// Two-requester round-robin arbiter (host vs calibration).
// The priority pointer moves only when both requesters contend.
module color_cfg_rr_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_host,
  input  logic req_cal,
  output logic gnt_host,
  output logic gnt_cal
);

  logic cal_prio_q, cal_prio_d;

  always_comb begin
    gnt_host   = 1'b0;
    gnt_cal    = 1'b0;
    cal_prio_d = cal_prio_q;
    if (en) begin
      if (req_host && req_cal) begin
        gnt_cal    = cal_prio_q;
        gnt_host   = !cal_prio_q;
        cal_prio_d = !cal_prio_q;
      end else begin
        gnt_host = req_host;
        gnt_cal  = req_cal;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cal_prio_q <= 1'b0;
    else        cal_prio_q <= cal_prio_d;
  end

endmodule

// File: rtl/color_config_scheduler.sv
// Stages gain/hue/brightness/saturation writes from host and calibration
// requesters in shadow registers and applies them atomically at a frame start.
module color_config_scheduler
  import color_cfg_pkg::*;
#(
  parameter int unsigned gainWidth       = 4,
  parameter int unsigned hueWidth        = 6,
  parameter int unsigned brightnessWidth = 6,
  parameter int unsigned saturationWidth = 6,
  parameter int unsigned gainReset       = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       hostValid,
  input  logic [1:0]                 hostAddr,
  input  logic [7:0]                 hostData,
  output logic                       hostReady,
  input  logic                       calValid,
  input  logic [1:0]                 calAddr,
  input  logic [7:0]                 calData,
  output logic                       calReady,
  input  logic                       commitReq,
  input  logic                       frameStart,
  output logic [gainWidth-1:0]       gain,
  output logic [hueWidth-1:0]        hue,
  output logic [brightnessWidth-1:0] brightness,
  output logic [saturationWidth-1:0] saturation,
  output logic                       pending,
  output logic                       commitDone
);

  cfg_state_e state_q, state_d;
  logic       rearm_q, rearm_d;
  logic       commit_done_q, commit_done_d;

  logic [gainWidth-1:0]       sh_gain_q, sh_gain_d, act_gain_q, act_gain_d;
  logic [hueWidth-1:0]        sh_hue_q,  sh_hue_d,  act_hue_q,  act_hue_d;
  logic [brightnessWidth-1:0] sh_bri_q,  sh_bri_d,  act_bri_q,  act_bri_d;
  logic [saturationWidth-1:0] sh_sat_q,  sh_sat_d,  act_sat_q,  act_sat_d;

  logic       host_gnt, cal_gnt, arb_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;

  // Readies must also stay low while reset is held, not only in APPLY.
  assign arb_en = reset && (state_q != APPLY);

  color_cfg_rr_arb u_arb (
    .clk      (clk),
    .rst_n    (reset),
    .en       (arb_en),
    .req_host (hostValid),
    .req_cal  (calValid),
    .gnt_host (host_gnt),
    .gnt_cal  (cal_gnt)
  );

  assign hostReady  = host_gnt;
  assign calReady   = cal_gnt;
  assign gain       = act_gain_q;
  assign hue        = act_hue_q;
  assign brightness = act_bri_q;
  assign saturation = act_sat_q;
  assign pending    = (state_q != IDLE);
  assign commitDone = commit_done_q;

  assign wr_addr = cal_gnt ? calAddr : hostAddr;
  assign wr_data = cal_gnt ? calData : hostData;

  always_comb begin
    sh_gain_d     = sh_gain_q;
    sh_hue_d      = sh_hue_q;
    sh_bri_d      = sh_bri_q;
    sh_sat_d      = sh_sat_q;
    act_gain_d    = act_gain_q;
    act_hue_d     = act_hue_q;
    act_bri_d     = act_bri_q;
    act_sat_d     = act_sat_q;
    state_d       = state_q;
    rearm_d       = rearm_q;
    commit_done_d = 1'b0;

    if (host_gnt || cal_gnt) begin
      case (wr_addr)
        FIELD_GAIN:       sh_gain_d = wr_data[gainWidth-1:0];
        FIELD_HUE:        sh_hue_d  = wr_data[hueWidth-1:0];
        FIELD_BRIGHTNESS: sh_bri_d  = wr_data[brightnessWidth-1:0];
        FIELD_SATURATION: sh_sat_d  = wr_data[saturationWidth-1:0];
        default: ;
      endcase
    end

    case (state_q)
      IDLE:  if (commitReq) state_d = ARMED;
      ARMED: if (frameStart) state_d = APPLY;
      APPLY: begin
        act_gain_d    = sh_gain_q;
        act_hue_d     = sh_hue_q;
        act_bri_d     = sh_bri_q;
        act_sat_d     = sh_sat_q;
        commit_done_d = 1'b1;
        state_d       = (rearm_q || commitReq) ? ARMED : IDLE;
        rearm_d       = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      rearm_q       <= 1'b0;
      commit_done_q <= 1'b0;
      sh_gain_q     <= gainWidth'(gainReset);
      sh_hue_q      <= '0;
      sh_bri_q      <= '0;
      sh_sat_q      <= '0;
      act_gain_q    <= gainWidth'(gainReset);
      act_hue_q     <= '0;
      act_bri_q     <= '0;
      act_sat_q     <= '0;
    end else begin
      state_q       <= state_d;
      rearm_q       <= rearm_d;
      commit_done_q <= commit_done_d;
      sh_gain_q     <= sh_gain_d;
      sh_hue_q      <= sh_hue_d;
      sh_bri_q      <= sh_bri_d;
      sh_sat_q      <= sh_sat_d;
      act_gain_q    <= act_gain_d;
      act_hue_q     <= act_hue_d;
      act_bri_q     <= act_bri_d;
      act_sat_q     <= act_sat_d;
    end
  end

endmodule

// File: tb/tb_color_config_scheduler.sv
// Scoreboard bench for color_config_scheduler: directed test-plan scenarios
// followed by randomized traffic against a behavioural model.
module tb_color_config_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       hostValid = 1'b0, calValid = 1'b0;
  logic [1:0] hostAddr = '0, calAddr = '0;
  logic [7:0] hostData = '0, calData = '0;
  logic       hostReady, calReady;
  logic       commitReq = 1'b0, frameStart = 1'b0;
  logic [3:0] gain;
  logic [5:0] hue, brightness, saturation;
  logic       pending, commitDone;

  color_config_scheduler #(
    .gainWidth       (4),
    .hueWidth        (6),
    .brightnessWidth (6),
    .saturationWidth (6),
    .gainReset       (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .hostValid  (hostValid),
    .hostAddr   (hostAddr),
    .hostData   (hostData),
    .hostReady  (hostReady),
    .calValid   (calValid),
    .calAddr    (calAddr),
    .calData    (calData),
    .calReady   (calReady),
    .commitReq  (commitReq),
    .frameStart (frameStart),
    .gain       (gain),
    .hue        (hue),
    .brightness (brightness),
    .saturation (saturation),
    .pending    (pending),
    .commitDone (commitDone)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic hr;
    logic cr;
    logic pend;
    logic done;
  } cyc_t;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] h;
    logic [7:0] b;
    logic [7:0] s;
  } vals_t;

  cyc_t  cyc_q[$];
  vals_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // Reference model state
  int unsigned sh[4];
  bit armed, applying, m_done, host_turn;
  bit h_v, c_v;
  logic [1:0] h_a, c_a;
  logic [7:0] h_d, c_d;

  task automatic chk(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int unsigned trunc(input logic [1:0] a, input logic [7:0] d);
    return (a == 2'd0) ? int'(d) % 16 : int'(d) % 64;
  endfunction

  function automatic vals_t snap();
    vals_t v;
    v.g = 8'(sh[0]); v.h = 8'(sh[1]); v.b = 8'(sh[2]); v.s = 8'(sh[3]);
    return v;
  endfunction

  function automatic vals_t reset_vals();
    vals_t v;
    v.g = 8'd4; v.h = 8'd0; v.b = 8'd0; v.s = 8'd0;
    return v;
  endfunction

  // Monitor: per-cycle handshake/status checks plus commit scoreboard
  vals_t mon_act;
  initial mon_act = reset_vals();

  always @(negedge clk) begin
    cyc_t e;
    if (cyc_q.size() != 0) begin
      e = cyc_q.pop_front();
      chk("hostReady", int'(hostReady), int'(e.hr));
      chk("calReady", int'(calReady), int'(e.cr));
      chk("pending", int'(pending), int'(e.pend));
      chk("commitDone", int'(commitDone), int'(e.done));
      if (!reset) mon_act = reset_vals();
      else if (commitDone) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_commit: got commitDone=1, expected no queued apply");
        end else mon_act = exp_q.pop_front();
      end
      chk("gain", int'(gain), int'(mon_act.g));
      chk("hue", int'(hue), int'(mon_act.h));
      chk("brightness", int'(brightness), int'(mon_act.b));
      chk("saturation", int'(saturation), int'(mon_act.s));
    end
  end

  task automatic model_reset();
    sh = '{4, 0, 0, 0};
    armed = 0; applying = 0; m_done = 0; host_turn = 1;
    exp_q.delete();
  endtask

  task automatic host_req(input logic [1:0] a, input logic [7:0] d);
    h_v = 1; h_a = a; h_d = d;
  endtask

  task automatic cal_req(input logic [1:0] a, input logic [7:0] d);
    c_v = 1; c_a = a; c_d = d;
  endtask

  // One clock cycle: drive inputs, predict the cycle, advance the model.
  task automatic step(input bit cr, input bit fs);
    bit hg, cg;
    cyc_t e;
    hostValid = h_v; hostAddr = h_a; hostData = h_d;
    calValid  = c_v; calAddr  = c_a; calData  = c_d;
    commitReq = cr;  frameStart = fs;
    hg = 0; cg = 0;
    if (!applying) begin
      if (h_v && c_v) begin
        hg = host_turn; cg = !host_turn;
        host_turn = cg;
      end else begin
        hg = h_v; cg = c_v;
      end
    end
    e.hr = hg; e.cr = cg; e.pend = armed || applying; e.done = m_done;
    cyc_q.push_back(e);
    if (hg) begin sh[h_a] = trunc(h_a, h_d); h_v = 0; end
    if (cg) begin sh[c_a] = trunc(c_a, c_d); c_v = 0; end
    m_done = applying;
    if (applying) begin
      applying = 0; armed = cr;
    end else if (armed) begin
      if (fs) begin armed = 0; applying = 1; exp_q.push_back(snap()); end
    end else if (cr) armed = 1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0);
  endtask

  task automatic drain();
    int guard = 0;
    while ((h_v || c_v) && guard < 20) begin step(0, 0); guard++; end
    chk("drain_bound", int'(h_v || c_v), 0);
  endtask

  task automatic do_reset(input int n);
    cyc_t e;
    reset = 1'b0; commitReq = 0; frameStart = 0;
    hostValid = h_v; calValid = c_v;
    model_reset();
    e = '0;
    repeat (n) begin cyc_q.push_back(e); @(posedge clk); #1; end
    reset = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    h_v = 0; c_v = 0; h_a = 0; c_a = 0; h_d = 0; c_d = 0;
    model_reset();
    @(posedge clk); #1;
    do_reset(3);
    idle(2);

    // Host hue/brightness, commit, frameStart 10 cycles later
    host_req(2'd1, 8'h2A); drain();
    host_req(2'd2, 8'hFF); drain();
    step(1, 0);
    idle(9);
    step(0, 1);
    idle(3);

    // Contention: both valid for 4 cycles
    for (int i = 0; i < 4; i++) begin
      if (!h_v) host_req(2'(i), 8'(8'h10 + i));
      if (!c_v) cal_req(2'(3 - i), 8'(8'h20 + i));
      step(0, 0);
    end
    drain();

    // Cal gain write coincident with triggering frameStart; host held across APPLY
    step(1, 0);
    idle(2);
    cal_req(2'd0, 8'h09);
    step(0, 1);
    host_req(2'd3, 8'h05);
    step(0, 0);
    drain();
    idle(2);

    // commitReq during APPLY re-arms
    step(1, 0);
    idle(2);
    step(0, 1);
    step(1, 0);
    idle(3);
    step(0, 1);
    idle(3);

    // commitReq and frameStart in same IDLE cycle only arms
    step(1, 1);
    idle(2);
    step(0, 1);
    idle(3);

    // Reset while armed with staged saturation
    host_req(2'd3, 8'h15); drain();
    step(1, 0);
    idle(2);
    do_reset(2);
    idle(2);
    step(0, 1);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (!h_v && $urandom_range(0, 2) == 0) host_req(2'($urandom_range(0, 3)), 8'($urandom));
      if (!c_v && $urandom_range(0, 2) == 0) cal_req(2'($urandom_range(0, 3)), 8'($urandom));
      if ($urandom_range(0, 399) == 0) do_reset(1);
      else step($urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
    end
    drain();
    idle(5);
    chk("all_commits_seen", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/color_config_scheduler.md
# color_config_scheduler

Configuration controller for the color modifier stage. It accepts parameter writes from two requesters, the host register port and the auto-calibration engine, through a round-robin arbiter and stages them in shadow registers. It applies the staged gain, hue, brightness and saturation values to the color modifier atomically at the next frame boundary after a commit request. Its active outputs drive the color modifier's gain/hue/brightness/saturation inputs directly.

## Interface
- gainWidth, 4, width of gain field
- hueWidth, 6, width of hue field
- brightnessWidth, 6, width of brightness field
- saturationWidth, 6, width of saturation field
- gainReset, 4, reset/default gain value (unity)

- clk  input  1  system clock, 50 MHz
- reset  input  1  asynchronous, active-low reset
- hostValid  input  1  host write request
- hostAddr  input  2  field select: 0 gain, 1 hue, 2 brightness, 3 saturation
- hostData  input  8  write data
- hostReady  output  1  host write accepted this cycle
- calValid / calAddr / calData / calReady  same as host, calibration requester
- commitReq  input  1  pulse; arm an atomic apply at next frame start
- frameStart  input  1  single-cycle pulse at first pixel of frame
- gain  output  gainWidth  active gain
- hue  output  hueWidth  active hue
- brightness  output  brightnessWidth  active brightness
- saturation  output  saturationWidth  active saturation
- pending  output  1  commit armed or applying
- commitDone  output  1  one-cycle pulse, new active values visible

## Operation
- Transfer occurs when valid && ready. Requester holds valid, addr and data stable until ready.
- hostReady/calReady are combinational from the valids, the RR pointer and the state. At most one is high per cycle. Both are low in APPLY.
- Arbitration: if only one requester is valid, it is granted. If both are valid, the one not granted last time wins. The pointer updates only on a contested grant. Reset pointer favours host.
- An accepted write updates the addressed shadow field at the clock edge. The field takes data[fieldWidth-1:0]; upper bits are discarded. Writes never alter the active outputs directly.
- FSM states: IDLE, ARMED, APPLY.
  - IDLE: commitReq -> ARMED. frameStart is ignored.
  - ARMED: writes are still accepted. frameStart -> APPLY. commitReq is ignored (already armed).
  - APPLY (exactly 1 cycle): active <= shadow at the end of the cycle. Next state is ARMED if a commitReq arrived during APPLY (sticky reArm flag, cleared on leaving), otherwise IDLE.
- pending = (state != IDLE).
- commitDone is a registered pulse, high the cycle after APPLY.
- Reset values: shadow and active gain = gainReset, all other fields 0. State IDLE, pointer host, reArm 0, pending 0, commitDone 0, both readies 0 while reset is asserted.
- Reset mid-operation: all state returns to reset values immediately. Staged writes and armed commits are lost.

## Timing
- Write accepted at edge N: shadow updated at N. It reaches the outputs only through a commit.
- frameStart sampled high in ARMED at cycle N: cycle N+1 is APPLY (readies low); cycle N+2 shows new active values, commitDone=1, pending=0 (unless re-armed).
- A write accepted in the same cycle as the triggering frameStart is included in the apply.
- commitReq and frameStart in the same IDLE cycle: the commit arms only, and waits for the next frameStart.
- Two writes to the same field before apply: the last accepted value wins.
- Latency from commitReq to outputs is unbounded; it is set by frameStart.

## Structure
- Shared package color_cfg_pkg holds:
  - field address constants FIELD_GAIN=0, FIELD_HUE=1, FIELD_BRIGHTNESS=2, FIELD_SATURATION=3
  - the FSM state enum (IDLE, ARMED, APPLY)
- Sub-module color_cfg_rr_arb holds the two-requester round-robin arbiter: valids in, grants out, pointer register with async active-low reset, plus an enable input driven low during APPLY.
- Top module holds the shadow/active registers, the FSM, reArm and commitDone.

## Test plan
- Reset: hold reset low, release -> gain=4, hue=brightness=saturation=0, pending=0, commitDone=0.
- Host writes hue=0x2A, brightness=0xFF, then commitReq, then frameStart 10 cycles later -> outputs unchanged until frameStart+2; then hue=0x2A, brightness=0x3F (truncated), one commitDone pulse.
- Both requesters valid for 4 cycles, writing distinct values -> grants alternate host, cal, host, cal; never both ready in one cycle.
- Armed state, frameStart and a cal gain=0x9 write in the same cycle -> gain=9 at frameStart+2; during APPLY both readies low and a held host request is granted the cycle after.
- commitReq pulsed during APPLY -> state returns to ARMED, pending stays 1; next frameStart applies again with a second commitDone.
- Reset asserted while ARMED with staged saturation=0x15 -> outputs and shadow return to reset values; a later frameStart causes no commitDone.
